// File: rtl/ngv_pwm_pkg.sv
// Shared definitions for the PWM generator: register-select encodings,
// reset defaults and the per-channel write-strobe bundle.
package ngv_pwm_pkg;

   typedef enum logic [1:0] {
      SEL_PER  = 2'd0,
      SEL_DUTY = 2'd1,
      SEL_DT   = 2'd2,
      SEL_RSV  = 2'd3
   } wr_sel_e;

   localparam logic [31:0] PER_RST_DEF  = 32'd42000000;
   localparam logic [31:0] DUTY_RST_DEF = 32'd21000000;

   // Decoded write strobes for a single channel; at most one bit is set.
   typedef struct packed {
      logic per;
      logic duty;
      logic dt;
   } wr_hit_t;

endpackage

// File: rtl/ngv_pwm_ch.sv
// One PWM channel: period counter, shadow/active registers that swap at period end,
// dead-time hold counter and registered complementary outputs.
module ngv_pwm_ch
   import ngv_pwm_pkg::*;
#(
   parameter int              CW       = 32,
   parameter int              DTW      = 8,
   parameter logic [CW-1:0]   PER_RST  = '0,
   parameter logic [CW-1:0]   DUTY_RST = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  wr_hit_t       wr,
   input  logic [CW-1:0] wr_data,
   output logic          out_p,
   output logic          out_n,
   output logic          wrap
);

   logic [CW-1:0]  per_sh_q, per_sh_d, duty_sh_q, duty_sh_d;
   logic [CW-1:0]  per_act_q, per_act_d, duty_act_q, duty_act_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [DTW-1:0] dt_sh_q, dt_sh_d, dt_act_q, dt_act_d;
   logic [DTW-1:0] hold_q, hold_d, hold_c;
   logic           raw, raw_q, raw_d, at_end, pass;
   logic           out_p_q, out_p_d, out_n_q, out_n_d, wrap_q, wrap_d;

   always_comb begin
      per_sh_d   = wr.per  ? wr_data            : per_sh_q;
      duty_sh_d  = wr.duty ? wr_data            : duty_sh_q;
      dt_sh_d    = wr.dt   ? wr_data[DTW-1:0]   : dt_sh_q;
      at_end     = (cnt_q == per_act_q);
      raw        = (cnt_q < duty_act_q);
      // Hold restarts in the very cycle raw changes, so that cycle is already blocked.
      hold_c     = (raw != raw_q) ? '0 : hold_q;
      pass       = (hold_c >= dt_act_q);

      per_act_d  = per_act_q;
      duty_act_d = duty_act_q;
      dt_act_d   = dt_act_q;
      cnt_d      = '0;
      hold_d     = '0;
      raw_d      = 1'b0;
      out_p_d    = 1'b0;
      out_n_d    = 1'b0;
      wrap_d     = 1'b0;

      // Load from the post-write shadow so a same-cycle write wins.
      if (!en || at_end) begin
         per_act_d  = per_sh_d;
         duty_act_d = duty_sh_d;
         dt_act_d   = dt_sh_d;
      end

      if (en) begin
         cnt_d   = at_end ? '0 : cnt_q + CW'(1);
         hold_d  = pass ? hold_c : hold_c + DTW'(1);
         raw_d   = raw;
         out_p_d = raw & pass;
         out_n_d = ~raw & pass;
         wrap_d  = at_end;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         per_sh_q   <= PER_RST;
         duty_sh_q  <= DUTY_RST;
         dt_sh_q    <= '0;
         per_act_q  <= PER_RST;
         duty_act_q <= DUTY_RST;
         dt_act_q   <= '0;
         cnt_q      <= '0;
         hold_q     <= '0;
         raw_q      <= 1'b0;
         out_p_q    <= 1'b0;
         out_n_q    <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         per_sh_q   <= per_sh_d;
         duty_sh_q  <= duty_sh_d;
         dt_sh_q    <= dt_sh_d;
         per_act_q  <= per_act_d;
         duty_act_q <= duty_act_d;
         dt_act_q   <= dt_act_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         raw_q      <= raw_d;
         out_p_q    <= out_p_d;
         out_n_q    <= out_n_d;
         wrap_q     <= wrap_d;
      end
   end

   assign out_p = out_p_q;
   assign out_n = out_n_q;
   assign wrap  = wrap_q;

endmodule

// File: rtl/ngv_pwm_gen.sv
// Multi-channel PWM generator top: decodes configuration writes into per-channel
// strobes and instantiates one ngv_pwm_ch per channel.
module ngv_pwm_gen
   import ngv_pwm_pkg::*;
#(
   parameter  int          CH       = 2,
   parameter  int          CW       = 32,
   parameter  int          DTW      = 8,
   parameter  logic [31:0] PER_RST  = PER_RST_DEF,
   parameter  logic [31:0] DUTY_RST = DUTY_RST_DEF,
   localparam int          CHW      = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [CH-1:0]  en,
   input  logic           wr_en,
   input  logic [CHW-1:0] wr_ch,
   input  logic [1:0]     wr_sel,
   input  logic [CW-1:0]  wr_data,
   output logic [CH-1:0]  out_p,
   output logic [CH-1:0]  out_n,
   output logic [CH-1:0]  wrap
);

   // An out-of-range wr_ch matches no instance and SEL_RSV matches no strobe,
   // so both are dropped without side effects.
   for (genvar i = 0; i < CH; i++) begin : g_ch
      wr_hit_t hit;
      logic    sel_ch;

      assign sel_ch   = wr_en && (wr_ch == CHW'(i));
      assign hit.per  = sel_ch && (wr_sel == SEL_PER);
      assign hit.duty = sel_ch && (wr_sel == SEL_DUTY);
      assign hit.dt   = sel_ch && (wr_sel == SEL_DT);

      ngv_pwm_ch #(
         .CW       (CW),
         .DTW      (DTW),
         .PER_RST  (CW'(PER_RST)),
         .DUTY_RST (CW'(DUTY_RST))
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en[i]),
         .wr      (hit),
         .wr_data (wr_data),
         .out_p   (out_p[i]),
         .out_n   (out_n[i]),
         .wrap    (wrap[i])
      );
   end

endmodule

// File: tb/tb_ngv_pwm_gen.sv
// Scoreboard bench for ngv_pwm_gen: a behavioural per-channel model pushes the
// expected {wrap,out_n,out_p} for each cycle; a monitor pops and compares after the edge.
module tb_ngv_pwm_gen;

   localparam int          CH  = 3;
   localparam int          CW  = 32;
   localparam int          DTW = 8;
   localparam int          CHW = 2;
   localparam logic [31:0] PR  = 32'd20;
   localparam logic [31:0] DR  = 32'd10;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [CH-1:0]  en = '0;
   logic           wr_en = 1'b0;
   logic [CHW-1:0] wr_ch = '0;
   logic [1:0]     wr_sel = '0;
   logic [CW-1:0]  wr_data = '0;
   logic [CH-1:0]  out_p, out_n, wrap;

   always #5 clk = ~clk;

   ngv_pwm_gen #(
      .CH(CH), .CW(CW), .DTW(DTW), .PER_RST(PR), .DUTY_RST(DR)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_sel(wr_sel), .wr_data(wr_data), .out_p(out_p), .out_n(out_n), .wrap(wrap)
   );

   int n_run = 0;
   int n_fail = 0;
   logic [3*CH-1:0] sb[$];
   logic [3*CH-1:0] sb_e;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model state: shadow/active config, count, and cycles spent at the current level.
   int unsigned s_per[CH], s_duty[CH], s_dt[CH];
   int unsigned a_per[CH], a_duty[CH], a_dt[CH];
   int unsigned cnt[CH], run_len[CH];
   bit          prev[CH], first[CH];

   function automatic void m_reset();
      for (int i = 0; i < CH; i++) begin
         s_per[i] = PR;  s_duty[i] = DR;  s_dt[i] = 0;
         a_per[i] = PR;  a_duty[i] = DR;  a_dt[i] = 0;
         cnt[i] = 0; run_len[i] = 0; prev[i] = 0; first[i] = 1;
      end
   endfunction

   // Called at a negedge with inputs already applied; pushes what the DUT must show after the next posedge.
   task automatic step();
      logic [CH-1:0] ep, enn, ew;
      ep = '0; enn = '0; ew = '0;
      for (int i = 0; i < CH; i++) begin
         int unsigned np, nd, nt;
         bit raw, pass;
         np = s_per[i]; nd = s_duty[i]; nt = s_dt[i];
         if (wr_en && int'(wr_ch) == i && wr_sel != 2'd3) begin
            if (wr_sel == 2'd0) np = wr_data;
            else if (wr_sel == 2'd1) nd = wr_data;
            else nt = wr_data & 32'hff;
         end
         if (!en[i]) begin
            cnt[i] = 0; first[i] = 1; run_len[i] = 0;
            a_per[i] = np; a_duty[i] = nd; a_dt[i] = nt;
         end else begin
            raw = (cnt[i] < a_duty[i]);
            if (first[i] || raw != prev[i]) run_len[i] = 0;
            else if (run_len[i] < 1000) run_len[i]++;
            pass   = (run_len[i] >= a_dt[i]);
            ep[i]  = raw && pass;
            enn[i] = !raw && pass;
            ew[i]  = (cnt[i] == a_per[i]);
            prev[i] = raw; first[i] = 0;
            if (cnt[i] == a_per[i]) begin
               cnt[i] = 0; a_per[i] = np; a_duty[i] = nd; a_dt[i] = nt;
            end else begin
               cnt[i]++;
            end
         end
         s_per[i] = np; s_duty[i] = nd; s_dt[i] = nt;
      end
      sb.push_back({ew, enn, ep});
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wr(input int ch, input int sel, input logic [31:0] data);
      wr_en = 1'b1; wr_ch = CHW'(ch); wr_sel = 2'(sel); wr_data = data;
      step();
      wr_en = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         sb_e = sb.pop_front();
         chk("outs", 32'({wrap, out_n, out_p}), 32'(sb_e));
         chk("excl", 32'(out_p & out_n), 32'd0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      repeat (3) @(negedge clk);
      chk("rst_outs", 32'({wrap, out_n, out_p}), 32'd0);
      rst = 1'b1;

      // Scaled defaults: ch0 high 10, low 11, wrap every 21; ch1/ch2 idle.
      en = 3'b001;
      run(50);

      // Mid-period reconfigure: old period completes, then 10-cycle period, duty 3, no dead-time.
      wr(0, 0, 9); wr(0, 1, 3); wr(0, 2, 0);
      run(45);

      // Dead-time 2 with duty 5.
      wr(0, 1, 5); wr(0, 2, 2);
      run(40);

      // Duty 0 then duty above period.
      wr(0, 1, 0);
      run(30);
      wr(0, 1, 12);
      run(30);

      // ch1 with period 0 (wrap every cycle); ch2 ordinary with dead-time 1, then re-enabled.
      wr(1, 0, 0); wr(1, 1, 1);
      wr(2, 0, 6); wr(2, 1, 4); wr(2, 2, 1);
      en = 3'b111;
      run(30);
      en = 3'b011;
      run(5);
      en = 3'b111;
      run(20);

      // Out-of-range channel and reserved select must not disturb anything.
      wr(3, 0, 5); wr(0, 3, 7); wr(3, 1, 2);
      run(25);

      // Asynchronous reset mid-period, then defaults again.
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("rst_async", 32'({wrap, out_n, out_p}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      m_reset();
      en = 3'b001;
      run(45);

      @(posedge clk);
      #2 chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
